// File: rtl/threebitcounter_pkg.sv
// Shared constants for the threebitcounter block: default width and reset count.
package threebitcounter_pkg;

   localparam int WIDTH_DEFAULT = 3;
   localparam int RESET_COUNT   = 0;

endpackage

// File: rtl/threebitcounter_checker.sv
// Simulation-only checker for threebitcounter; bind it to the counter instance.
// Not part of the synthesised netlist.
module threebitcounter_checker
   import threebitcounter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input logic             clk,
   input logic             rst,
   input logic             ld,
   input logic             inc,
   input logic [WIDTH-1:0] data_in,
   input logic [WIDTH-1:0] data_out
);

   logic             seen_reset;
   logic             prev_rst;
   logic             prev_ld;
   logic             prev_inc;
   logic [WIDTH-1:0] prev_data;
   logic [WIDTH-1:0] prev_count;
   logic [WIDTH-1:0] expected;

   always_comb begin
      expected = prev_count;
      if (prev_rst) begin
         expected = WIDTH'(RESET_COUNT);
      end else if (prev_ld) begin
         expected = prev_data;
      end else if (prev_inc) begin
         expected = prev_count + WIDTH'(1);
      end
   end

   // Compares the count produced by the previous edge against the inputs
   // sampled at that edge; only meaningful once a reset edge has been seen.
   always_ff @(posedge clk) begin
      if (seen_reset) begin
         assert (data_out == expected);
      end
      seen_reset <= seen_reset | rst;
      prev_rst   <= rst;
      prev_ld    <= ld;
      prev_inc   <= inc;
      prev_data  <= data_in;
      prev_count <= data_out;
   end

endmodule

// File: rtl/threebitcounter.sv
// Loadable WIDTH-bit up counter with synchronous active-high reset.
// Priority at each edge: rst, then ld, then inc, then hold.
module threebitcounter
   import threebitcounter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic             inc,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   logic [WIDTH-1:0] count;

   // Increment wraps naturally at 2^WIDTH; there is no carry or sticky flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= WIDTH'(RESET_COUNT);
      end else if (ld) begin
         count <= data_in;
      end else if (inc) begin
         count <= count + WIDTH'(1);
      end
   end

   assign data_out = count;

endmodule

// File: tb/tb_threebitcounter.sv
// Scoreboard bench for threebitcounter: driver queues expected counts, monitor checks after each edge.
module tb_threebitcounter;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic         ld;
   logic         inc;
   logic [W-1:0] data_in;
   logic [W-1:0] data_out;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks   = 0;
   int           failures = 0;

   threebitcounter #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .ld       (ld),
      .inc      (inc),
      .data_in  (data_in),
      .data_out (data_out)
   );

   // Clock: 20 ns period, first rising edge at 10 ns.
   always #10 clk = ~clk;

   // Driver: apply inputs on the falling edge, queue the count expected after the next rising edge.
   task automatic step(input logic r, input logic l, input logic i,
                       input logic [W-1:0] d, input logic [W-1:0] e,
                       input string nm, input bit glitch = 1'b0);
      rst = r; ld = l; inc = i; data_in = d;
      exp_q.push_back(e);
      name_q.push_back(nm);
      if (glitch) begin
         #3 rst = 1'b1;
         #3 rst = 1'b0;
      end
      @(negedge clk);
   endtask

   // Monitor: every rising edge produces a new count; compare it 1 ns later.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [W-1:0] e;
         string        nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         checks++;
         if (data_out !== e) begin
            failures++;
            $display("FAIL %s: data_out=%0d expected=%0d at %0t", nm, data_out, e, $time);
         end
      end
   end

   initial begin
      // Hold reset through first edge, count 1..7,0,1,2.
      step(1, 0, 1, 3'd0, 3'd0, "reset_hold");
      for (int k = 1; k <= 10; k++) begin
         step(0, 0, 1, 3'd0, W'(k), "count_up");
      end
      // Load priority over increment.
      step(0, 0, 1, 3'd0, 3'd3, "count_to_3");
      step(0, 1, 1, 3'd5, 3'd5, "load_over_inc");
      step(0, 0, 1, 3'd0, 3'd6, "inc_after_load");
      // Reset priority over load.
      step(1, 1, 0, 3'd6, 3'd0, "reset_over_load");
      // Hold for 5 edges at 4.
      step(0, 1, 0, 3'd4, 3'd4, "load_4");
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 0, 3'd2, 3'd4, "hold");
      end
      // Wrap via load.
      step(0, 1, 0, 3'd7, 3'd7, "load_7");
      step(0, 0, 1, 3'd0, 3'd0, "wrap_7_to_0");
      // Loading the current value leaves the count unchanged.
      step(0, 1, 1, 3'd0, 3'd0, "load_same");
      // Mid-count reset, then resume from 0.
      step(0, 1, 0, 3'd5, 3'd5, "load_5");
      step(1, 0, 1, 3'd0, 3'd0, "mid_reset");
      step(0, 0, 1, 3'd0, 3'd1, "resume_after_reset");
      // Reset pulse between edges must not affect the count.
      step(0, 0, 1, 3'd0, 3'd2, "rst_glitch", 1'b1);
      step(0, 0, 0, 3'd0, 3'd2, "hold_after_glitch", 1'b1);
      step(0, 1, 0, 3'd6, 3'd6, "load_6");
      step(0, 0, 1, 3'd0, 3'd7, "inc_to_7");
      step(0, 0, 0, 3'd0, 3'd7, "hold_7");

      for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
         @(negedge clk);
      end
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
